// File: rtl/sonic_sync_ring_gearbox_if.sv
// ---------------------------------------------------------------------------
// sonic_sync_ring_gearbox_if
// Bundle of the symbol-in / word-out signals of the sonic_sync_ring_gearbox.
//   in_valid, in_data      : narrow symbol stream into the gearbox
//   out_valid, out_ready,
//   out_data               : first-word-fall-through word read port
//   level, partial_cnt,
//   full, empty, overflow  : status
// modport slave  : the gearbox itself
// modport master : the producer/consumer (or a testbench) driving it
// ---------------------------------------------------------------------------
interface sonic_sync_ring_gearbox_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 128,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(OUT_W / IN_W);

  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [AW:0]      level;
  logic [CW-1:0]    partial_cnt;
  logic             full;
  logic             empty;
  logic             overflow;

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, level, partial_cnt, full, empty, overflow
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, level, partial_cnt, full, empty, overflow
  );
endinterface

// File: rtl/sonic_sync_ring_gearbox.sv
// ---------------------------------------------------------------------------
// sonic_sync_ring_gearbox
// Packs IN_W-bit symbols (first symbol in the LSBs) into OUT_W-bit words and
// stores them in a DEPTH-entry ring held in an inferred simple dual-port RAM
// with registered read. Words leave through a first-word-fall-through
// valid/ready port.
// Ports:
//   clock    : single clock, rising edge
//   reset_n  : synchronous active-low reset, overrides everything
//   flush    : synchronous clear of packer, ring and overflow
//   bus      : sonic_sync_ring_gearbox_if.slave (symbol in, word out, status)
// ---------------------------------------------------------------------------
module sonic_sync_ring_gearbox #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 128,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  sonic_sync_ring_gearbox_if.slave bus
);
  localparam int RATIO = OUT_W / IN_W;
  localparam int CW    = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_SYM = CW'(RATIO - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   TWO_LVL  = (AW + 1)'(2);

  logic                   clear;
  logic [OUT_W-IN_W-1:0]  acc;        // symbols 0..RATIO-2 of the current word
  logic [OUT_W-1:0]       wr_word;
  logic [CW-1:0]          part_q, part_d;
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q, rd_addr;
  logic [AW:0]            level_q, level_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_W-1:0]       dout_q;
  logic                   ovf_q, ovf_d;
  logic                   complete, push, pop, rd_en, wr_en;
  logic [OUT_W-1:0]       mem [DEPTH];

  assign clear = !reset_n || flush;

  // One register per symbol slot; the last symbol is never stored here, it
  // goes straight into the RAM word together with the accumulated bits.
  for (genvar gi = 0; gi < RATIO - 1; gi++) begin : g_slot
    logic [IN_W-1:0] sym_q;
    always_ff @(posedge clock) begin
      if (clear) begin
        sym_q <= '0;
      end else if (bus.in_valid && (part_q == CW'(gi))) begin
        sym_q <= bus.in_data;
      end
    end
    assign acc[gi*IN_W +: IN_W] = sym_q;
  end

  assign complete = bus.in_valid && (part_q == LAST_SYM);
  // Full test uses the pre-edge level, so a same-cycle pop cannot make room.
  assign push     = complete && (level_q != FULL_LVL);
  assign pop      = out_valid_q && bus.out_ready;
  assign wr_word  = {bus.in_data, acc};
  assign wr_en    = push && !clear;

  always_comb begin
    part_d      = part_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    rd_en       = 1'b0;
    rd_addr     = rd_ptr_q;

    if (bus.in_valid) begin
      part_d = (part_q == LAST_SYM) ? '0 : part_q + 1'b1;
    end
    if (complete && !push) begin
      ovf_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // The output register always holds the word at rd_ptr. On a pop the
    // successor is fetched in the same edge if it was already stored
    // (level >= 2); otherwise the register refills once a word is counted.
    if (pop) begin
      rd_addr     = rd_ptr_q + 1'b1;
      rd_en       = (level_q >= TWO_LVL);
      out_valid_d = (level_q >= TWO_LVL);
    end else if (!out_valid_q && (level_q != '0)) begin
      rd_en       = 1'b1;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_word;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      part_q      <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      part_q      <= part_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = dout_q;
  assign bus.level       = level_q;
  assign bus.partial_cnt = part_q;
  assign bus.full        = (level_q == FULL_LVL);
  assign bus.empty       = (level_q == '0);
  assign bus.overflow    = ovf_q;
endmodule

// File: doc/sonic_sync_ring_gearbox.md
Name: sonic_sync_ring_gearbox

Overview:
- Single-clock, parametrised narrow-in/wide-out ring buffer.
- Packs IN_W-bit symbols into OUT_W-bit words and stores them in a DEPTH-entry ring.
- Presents the words on a valid/ready read port, with occupancy, flush and sticky overflow reporting.
- Sits between the 2-bit sync symbol stream and the 128-bit host/DMA side. Replaces fixed-geometry dual-half rings with one generic block.

Parameters:
IN_W, 2, input symbol width in bits; must divide OUT_W
OUT_W, 128, output word width in bits; RATIO = OUT_W/IN_W (default 64)
DEPTH, 256, ring depth in OUT_W words; power of two, >= 2
AW, $clog2(DEPTH), ring address width (derived, do not override)

Ports:
clock  input  1  single clock; all logic on rising edge
reset_n  input  1  synchronous, active-low reset
flush  input  1  synchronous clear of packer, ring and overflow
in_valid  input  1  in_data carries a symbol this cycle
in_data  input  IN_W  input symbol
out_valid  output  1  out_data holds the oldest stored word
out_ready  input  1  consumer accepts the word when out_valid is high
out_data  output  OUT_W  oldest stored word
level  output  AW+1  words held, 0..DEPTH, including any word shown on out_data
partial_cnt  output  $clog2(RATIO)  symbols accumulated in the current word
full  output  1  level == DEPTH
empty  output  1  level == 0
overflow  output  1  sticky: at least one completed word was dropped

Behaviour:
- Reset (reset_n=0 at an edge):
  - level=0, partial_cnt=0, out_valid=0, empty=1, full=0, overflow=0, out_data=0.
  - Read and write pointers return to 0.
  - Reset overrides all other inputs.
- Flush (flush=1, reset_n=1): same effect as reset on all state. in_valid and out_ready are ignored in that cycle.
- Packing:
  - Each in_valid cycle stores in_data at bit slice [partial_cnt*IN_W +: IN_W] of the accumulating word and increments partial_cnt.
  - The first symbol lands in the LSBs.
- Word completion: the edge where in_valid=1 and partial_cnt=RATIO-1 completes a word.
  - The word written is {in_data, accumulated bits}.
  - partial_cnt wraps to 0. The write pointer increments mod DEPTH.
- Full handling:
  - The full test uses the level held before the edge.
  - If level==DEPTH at completion, the word is dropped and overflow is set; a pop in the same cycle does not rescue it.
  - partial_cnt still wraps to 0, so packing realigns to the next symbol.
- overflow stays 1 until reset or flush.
- Read side:
  - Behaves as a first-word-fall-through output.
  - out_valid=1 whenever a word is available.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - A pop occurs on an edge with out_valid=1 and out_ready=1. The next word is presented on the following cycle with no bubble when level>=2 before the pop.
- Latency:
  - A word completed at edge N into an empty ring gives out_valid=1 after edge N+1, i.e. one cycle after the word is stored.
  - level increments at edge N.
- level arithmetic:
  - level updates by +1 on push, -1 on pop, and 0 when both happen together.
  - A dropped word is not a push.
  - level never exceeds DEPTH and never goes below 0.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0 with no gap. After N pushes the ring holds words in push order regardless of pointer position.
- out_ready while out_valid=0 has no effect.
- in_valid=0 holds the packer state. Gaps between symbols are allowed.
- Memory is inferred single-clock simple dual-port RAM: one write port, one read port. Read data must be registered.

Test Plan:
- Reset, then 64 symbols in_data=i[1:0] (i=0..63) with out_ready=1 -> one word 0xE4E4…E4 (bits[1:0]=0, [3:2]=1, [5:4]=2, [7:6]=3, repeating). out_valid rises one cycle after the 64th symbol. level goes 0 -> 1 -> 0.
- out_ready=0; push 256 words with word k's symbols all = k[1:0] -> full=1, level=256, overflow=0. A 257th word -> dropped, overflow=1, level stays 256. Drain all 256 -> order 0..255 with no 257th word. overflow stays 1 until flush.
- Fill to 256, then one completion edge with a simultaneous pop -> word dropped, overflow=1, level=255.
- 40 symbols, then flush -> partial_cnt=0, level=0, overflow=0. The next 64 symbols form one clean word with no residue from the first 40.
- Continuous 2-bit stream with out_ready toggling every cycle for 600 words (pointer wraps twice) -> every word returned in order, out_data stable while stalled, no loss while level<256.
- reset_n=0 asserted mid-word and mid-drain (level=10) -> next edge: level=0, out_valid=0, partial_cnt=0. In-flight data is discarded.
